// File: rtl/teclado_digitos.sv
// teclado_digitos
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases,
//   decodes keys and accumulates decimal digits. '#' emits the accumulated
//   digits on digitos_value with a one-cycle digitos_valid strobe.
// Ports
//   clk            system clock
//   rst            synchronous reset, active-high
//   enable         1 = scan/accept keys, 0 = held at reset values
//   col_matricial  keypad columns, active-low, asynchronous
//   lin_matricial  keypad rows, active-low one-hot
//   digitos_value  packet, slot k = [4k+3:4k], slot 0 = newest digit
//   digitos_valid  one-cycle strobe qualifying digitos_value
module teclado_digitos #(
    parameter int SCAN_CYC     = 1000,       // must exceed SETTLE
    parameter int DEBOUNCE_CYC = 10000,
    parameter int TIMEOUT_CYC  = 500000000,
    parameter int MAX_DIG      = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [3:0]             col_matricial,
    output logic [3:0]             lin_matricial,
    output logic [4*MAX_DIG-1:0]   digitos_value,
    output logic                   digitos_valid
);
    localparam int BW = 4*MAX_DIG;
    localparam int SW = $clog2(SCAN_CYC+1);
    localparam int DW = $clog2(DEBOUNCE_CYC+1);
    localparam int TW = $clog2(TIMEOUT_CYC+1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYC-1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC-1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC-1);
    // After a row change the synchronized columns still show the previous
    // row for two cycles; hits are ignored until they reflect the new row.
    localparam logic [SW-1:0] SETTLE    = SW'(2);

    localparam logic [3:0] K_STAR = 4'hE;
    localparam logic [3:0] K_HASH = 4'hF;

    typedef enum logic [1:0] {S_SCAN, S_DEB_PRESS, S_HELD, S_DEB_REL} state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_col_s1, r_col_s2;
    logic [1:0]      r_row, w_row_nxt;
    logic [SW-1:0]   r_scan_cnt, w_scan_nxt;
    logic [DW-1:0]   r_deb_cnt, w_deb_nxt;
    logic [3:0]      r_pat, w_pat_nxt;
    logic            w_accept;
    logic            r_key_vld;
    logic [3:0]      r_key, w_code;
    logic [1:0]      w_cidx;
    logic            w_hit;
    logic [BW-1:0]   r_buf, r_value;
    logic            r_valid;
    logic [TW-1:0]   r_tmo;
    logic            w_clr, w_nonempty;

    assign w_clr         = rst | ~enable;
    assign lin_matricial = ~(4'b0001 << r_row);
    assign digitos_value = r_value;
    assign digitos_valid = r_valid;
    // Digits enter at slot 0, so slot 0 is F only when the buffer is empty.
    assign w_nonempty    = (r_buf[3:0] != 4'hF);

    // Exactly one low column is a hit; column index follows.
    always_comb begin
        w_hit  = 1'b1;
        w_cidx = 2'd0;
        case (r_col_s2)
            4'b1110: w_cidx = 2'd0;
            4'b1101: w_cidx = 2'd1;
            4'b1011: w_cidx = 2'd2;
            4'b0111: w_cidx = 2'd3;
            default: w_hit  = 1'b0;
        endcase
    end

    // Key code: 0-9 digits, A-D letters, E '*', F '#'.
    always_comb begin
        w_code = 4'hA;
        case ({r_row, w_cidx})
            4'h0: w_code = 4'h1;  4'h1: w_code = 4'h2;
            4'h2: w_code = 4'h3;  4'h3: w_code = 4'hA;
            4'h4: w_code = 4'h4;  4'h5: w_code = 4'h5;
            4'h6: w_code = 4'h6;  4'h7: w_code = 4'hB;
            4'h8: w_code = 4'h7;  4'h9: w_code = 4'h8;
            4'hA: w_code = 4'h9;  4'hB: w_code = 4'hC;
            4'hC: w_code = K_STAR; 4'hD: w_code = 4'h0;
            4'hE: w_code = K_HASH; 4'hF: w_code = 4'hD;
            default: w_code = 4'hA;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_scan_nxt  = r_scan_cnt;
        w_deb_nxt   = r_deb_cnt;
        w_pat_nxt   = r_pat;
        w_accept    = 1'b0;
        case (r_state)
            S_SCAN: begin
                if (w_hit && r_scan_cnt >= SETTLE) begin
                    w_state_nxt = S_DEB_PRESS;
                    w_pat_nxt   = r_col_s2;
                    w_deb_nxt   = DW'(1);   // detection cycle counts as stable
                end else if (r_scan_cnt == SCAN_LAST) begin
                    w_scan_nxt = '0;
                    w_row_nxt  = r_row + 2'd1;
                end else begin
                    w_scan_nxt = r_scan_cnt + SW'(1);
                end
            end
            S_DEB_PRESS: begin
                if (r_col_s2 != r_pat) begin
                    w_state_nxt = S_SCAN;   // scan counter kept: same row resumes
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = S_HELD;
                    w_accept    = 1'b1;
                end else begin
                    w_deb_nxt = r_deb_cnt + DW'(1);
                end
            end
            S_HELD: begin
                if (r_col_s2 != r_pat) begin
                    w_state_nxt = S_DEB_REL;
                    w_deb_nxt   = '0;
                end
            end
            S_DEB_REL: begin
                if (w_hit) begin
                    w_state_nxt = S_HELD;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state_nxt = S_SCAN;
                    w_scan_nxt  = '0;
                end else begin
                    w_deb_nxt = r_deb_cnt + DW'(1);
                end
            end
            default: w_state_nxt = S_SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_col_s1   <= 4'hF;
            r_col_s2   <= 4'hF;
            r_state    <= S_SCAN;
            r_row      <= 2'd0;
            r_scan_cnt <= '0;
            r_deb_cnt  <= '0;
            r_pat      <= 4'hF;
            r_key_vld  <= 1'b0;
            r_key      <= 4'h0;
            r_buf      <= {BW{1'b1}};
            r_value    <= {BW{1'b1}};
            r_valid    <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_col_s1   <= col_matricial;
            r_col_s2   <= r_col_s1;
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_scan_cnt <= w_scan_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_pat      <= w_pat_nxt;
            r_key_vld  <= w_accept;
            r_key      <= w_code;
            r_valid    <= 1'b0;
            // Key actions outrank the timeout; letters fall through untouched.
            if (r_key_vld && r_key <= 4'd9) begin
                r_buf <= {r_buf[BW-5:0], r_key};
                r_tmo <= '0;
            end else if (r_key_vld && r_key == K_STAR) begin
                r_buf <= {BW{1'b1}};
                r_tmo <= '0;
            end else if (r_key_vld && r_key == K_HASH) begin
                if (w_nonempty) begin
                    r_value <= r_buf;
                    r_valid <= 1'b1;
                end
                r_buf <= {BW{1'b1}};
                r_tmo <= '0;
            end else if (w_nonempty) begin
                if (r_tmo == TMO_LAST) begin
                    r_buf <= {BW{1'b1}};
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + TW'(1);
                end
            end else begin
                r_tmo <= '0;
            end
        end
    end
endmodule
